// File: rtl/fifo_ctrl.sv
// FIFO control-path state register plus head/tail/occupancy datapath.
// Registers the next state from fifo_ns and decodes register-file strobes and status flags.
module fifo_ctrl #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        next_state,
  output logic [2:0]        state,
  output logic [ADDR_W:0]   data_count,
  output logic [ADDR_W-1:0] head,
  output logic [ADDR_W-1:0] tail,
  output logic              we,
  output logic              re,
  output logic              full,
  output logic              empty,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              rd_ack,
  output logic              rd_err
);

  typedef enum logic [2:0] {
    INIT     = 3'b000,
    WRITE    = 3'b001,
    READ     = 3'b010,
    WR_ERROR = 3'b101,
    RD_ERROR = 3'b110,
    NO_OP    = 3'b111
  } state_e;

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

  logic do_write;
  logic do_read;

  // Decoded from registered state/count only, so fifo_ns sees no combinational loop.
  assign full     = (data_count == DEPTH);
  assign empty    = (data_count == '0);
  assign do_write = (state == WRITE) & ~full;
  assign do_read  = (state == READ) & ~empty;

  assign we     = do_write;
  assign wr_ack = do_write;
  assign re     = do_read;
  assign rd_ack = do_read;
  assign wr_err = (state == WR_ERROR);
  assign rd_err = (state == RD_ERROR);

  // Illegal codes 011/100 are stored verbatim; they decode to no action, exactly like NO_OP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= INIT;
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values,
      // so the pointer update below uses the state that was current this cycle.
      state <= next_state;
      if (do_write) begin
        tail       <= tail + ADDR_W'(1);
        data_count <= data_count + (ADDR_W+1)'(1);
      end else if (do_read) begin
        head       <= head + ADDR_W'(1);
        data_count <= data_count - (ADDR_W+1)'(1);
      end
    end
  end

endmodule
